pc_addr_unit: RTL and testbench

Program-counter and memory-address stage directly downstream of the CPU control state machine. Consumes the controller's `load_pc`, `reset_pc`, `load_addr`, `addr_sel`, `load_ir`, `halt` and `mem_cmd` strobes and produces the 9-bit word address and gated command driven onto the 512-word instruction/data memory. Also holds the halt latch, the current-instruction address, and a retired-instruction counter for debug.

---
 rtl/pc_addr_unit.sv | 63 ++++++
 tb/tb_pc_addr_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_addr_unit.sv
// PC, data-address, instruction-address, halt latch and retire counter feeding the memory port.
// Registers update one edge after their strobe; mem_addr/mem_cmd_out are combinational; no backpressure.
module pc_addr_unit #(
   parameter int AW = 9,
   parameter int DW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_pc,
   input  logic [1:0]    reset_pc,
   input  logic [DW-1:0] sximm8,
   input  logic [DW-1:0] rd_value,
   input  logic          load_addr,
   input  logic [DW-1:0] datapath_out,
   input  logic          addr_sel,
   input  logic          load_ir,
   input  logic          halt,
   input  logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [1:0]    mem_cmd_out,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] data_addr,
   output logic [AW-1:0] instr_pc,
   output logic          halted,
   output logic [CW-1:0] instr_count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= '0;
         data_addr   <= '0;
         instr_pc    <= '0;
         halted      <= 1'b0;
         instr_count <= '0;
      end else begin
         if (halt)
            halted <= 1'b1;
         // Gating uses the registered halt, so a same-cycle strobe still completes.
         if (!halted) begin
            if (load_pc) begin
               unique case (reset_pc)
                  2'b00: pc <= pc + AW'(1);
                  2'b01: pc <= '0;
                  2'b10: pc <= pc + sximm8[AW-1:0];
                  2'b11: pc <= rd_value[AW-1:0];
               endcase
            end
            if (load_addr)
               data_addr <= datapath_out[AW-1:0];
            if (load_ir) begin
               instr_pc <= pc;
               if (instr_count != '1)
                  instr_count <= instr_count + CW'(1);
            end
         end
      end
   end

   assign mem_addr    = addr_sel ? pc : data_addr;
   assign mem_cmd_out = halted ? 2'b00 : mem_cmd;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Randomized and directed bench for pc_addr_unit against an arithmetic reference model.
module tb_pc_addr_unit;
   localparam int AW = 9;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int MW = 1 << AW;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_pc, load_addr, addr_sel, load_ir, halt;
   logic [1:0]    reset_pc, mem_cmd;
   logic [DW-1:0] sximm8, rd_value, datapath_out;
   logic [AW-1:0] mem_addr, pc, data_addr, instr_pc;
   logic [1:0]    mem_cmd_out;
   logic          halted;
   logic [CW-1:0] instr_count;

   pc_addr_unit #(.AW(AW), .DW(DW), .CW(CW)) dut (
      .clk(clk), .reset(reset), .load_pc(load_pc), .reset_pc(reset_pc),
      .sximm8(sximm8), .rd_value(rd_value), .load_addr(load_addr),
      .datapath_out(datapath_out), .addr_sel(addr_sel), .load_ir(load_ir),
      .halt(halt), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .mem_cmd_out(mem_cmd_out), .pc(pc), .data_addr(data_addr),
      .instr_pc(instr_pc), .halted(halted), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: plain integers, modulo arithmetic on the address space.
   int m_pc, m_da, m_ipc, m_cnt;
   bit m_halt;

   function automatic int wrap(input int x);
      return ((x % MW) + MW) % MW;
   endfunction

   task automatic model_reset();
      m_pc = 0; m_da = 0; m_ipc = 0; m_cnt = 0; m_halt = 0;
   endtask

   task automatic model_edge();
      int npc;
      npc = m_pc;
      if (!m_halt) begin
         if (load_pc) begin
            case (reset_pc)
               2'b00: npc = wrap(m_pc + 1);
               2'b01: npc = 0;
               2'b10: npc = wrap(m_pc + int'($signed(sximm8)));
               default: npc = wrap(int'(rd_value));
            endcase
         end
         if (load_addr) m_da = wrap(int'(datapath_out));
         if (load_ir) begin
            m_ipc = m_pc;
            if (m_cnt < CMAX) m_cnt++;
         end
         m_pc = npc;
      end
      if (halt) m_halt = 1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".data_addr"}, data_addr, m_da);
      check({tag, ".instr_pc"}, instr_pc, m_ipc);
      check({tag, ".halted"}, halted, m_halt);
      check({tag, ".instr_count"}, instr_count, m_cnt);
      check({tag, ".mem_addr"}, mem_addr, addr_sel ? m_pc : m_da);
      check({tag, ".mem_cmd_out"}, mem_cmd_out, m_halt ? 0 : int'(mem_cmd));
   endtask

   task automatic tick(input string tag, input bit chk);
      @(posedge clk);
      model_edge();
      #1;
      if (chk) check_all(tag);
   endtask

   task automatic idle();
      load_pc = 0; reset_pc = 2'b00; load_addr = 0; load_ir = 0; halt = 0;
      sximm8 = '0; rd_value = '0; datapath_out = '0; addr_sel = 1; mem_cmd = 2'b00;
   endtask

   task automatic jump(input int tgt);
      idle(); load_pc = 1; reset_pc = 2'b11; rd_value = DW'(tgt);
      tick("jump", 1);
   endtask

   task automatic pulse_reset();
      #2 reset = 1;
      model_reset();
      #1 check_all("async_rst");
      #1 reset = 0;
   endtask

   initial begin
      logic [7:0] b;
      idle();
      reset = 1;
      model_reset();
      #1 check_all("reset");
      #6 reset = 0;

      // Controller reset state: clear PC, first fetch from 0.
      load_pc = 1; reset_pc = 2'b01;
      tick("first", 1);
      check("first_pc", pc, 0);

      // Sequential fetch.
      for (int i = 0; i < 3; i++) begin
         idle(); load_pc = 1; load_ir = 1; addr_sel = 1;
         tick("seq", 1);
         check("seq_pc", pc, i + 1);
         check("seq_ipc", instr_pc, i);
         check("seq_maddr", mem_addr, i + 1);
      end
      check("seq_count", instr_count, 3);

      // Branches, including negative offset and wrap.
      jump(10);
      idle(); load_pc = 1; reset_pc = 2'b10; sximm8 = 16'hFFFC;
      tick("br_neg", 1);
      check("br_neg_pc", pc, 6);
      jump(510);
      idle(); load_pc = 1; reset_pc = 2'b10; sximm8 = 16'h0005;
      tick("br_wrap", 1);
      check("br_wrap_pc", pc, 3);
      jump(511);
      idle(); load_pc = 1;
      tick("inc_wrap", 1);
      check("inc_wrap_pc", pc, 0);

      // Register target truncation and data address select, issued together.
      idle(); load_pc = 1; reset_pc = 2'b11; rd_value = 16'h1234;
      load_addr = 1; datapath_out = 16'h01FF;
      tick("bx", 1);
      check("bx_pc", pc, 9'h034);
      addr_sel = 0;
      #1 check("daddr_maddr", mem_addr, 9'h1FF);
      idle(); load_addr = 1; datapath_out = 16'hFE23; addr_sel = 0;
      tick("daddr_trunc", 1);
      check("daddr_trunc", data_addr, 9'h023);

      // Halt in the same cycle as an increment.
      jump(7);
      idle(); halt = 1; load_pc = 1; mem_cmd = 2'b01;
      tick("halt", 1);
      check("halt_pc", pc, 8);
      check("halt_flag", halted, 1);
      idle(); load_pc = 1; load_ir = 1; load_addr = 1; datapath_out = 16'h0042; mem_cmd = 2'b01;
      tick("frozen", 1);
      check("frozen_pc", pc, 8);
      check("frozen_cmd", mem_cmd_out, 0);

      // Counter saturation.
      pulse_reset();
      idle(); load_ir = 1;
      for (int i = 0; i < 65534; i++) tick("preload", 0);
      check("cnt_fffe", instr_count, 16'hFFFE);
      tick("sat1", 1);
      tick("sat2", 1);
      check("cnt_sat", instr_count, 16'hFFFF);

      // Asynchronous reset while halted.
      jump(9'h55);
      idle(); halt = 1;
      tick("halt2", 1);
      idle(); mem_cmd = 2'b01;
      #3 reset = 1;
      model_reset();
      #1;
      check("ar_pc", pc, 0);
      check("ar_halted", halted, 0);
      check("ar_count", instr_count, 0);
      check("ar_cmd", mem_cmd_out, 2'b01);
      #2 reset = 0;

      // Random traffic, with occasional halts and async resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) pulse_reset();
         load_pc      = $urandom_range(0, 1);
         reset_pc     = 2'($urandom_range(0, 3));
         b            = 8'($urandom);
         sximm8       = {{8{b[7]}}, b};
         rd_value     = 16'($urandom);
         load_addr    = $urandom_range(0, 1);
         datapath_out = 16'($urandom);
         addr_sel     = $urandom_range(0, 1);
         load_ir      = $urandom_range(0, 1);
         halt         = ($urandom_range(0, 59) == 0);
         mem_cmd      = 2'($urandom_range(0, 3));
         #1 check("rnd_maddr", mem_addr, addr_sel ? m_pc : m_da);
         check("rnd_cmd", mem_cmd_out, m_halt ? 0 : int'(mem_cmd));
         tick("rnd", 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
